// File: rtl/accel_inst_decoder.sv
`default_nettype none
// ============================================================================
// Module      : accel_inst_decoder
// Description : Instruction decode stage. Validates opcodes, expands bursts
//               into per-element beats and buffers them in an output FIFO.
// Revision    : 1.0
// ============================================================================
module accel_inst_decoder #(
    parameter int UNIT_ID_WIDTH = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int OUT_DEPTH     = 4,
    parameter int CNT_WIDTH     = 8,
    parameter int INST_WIDTH    = 2*UNIT_ID_WIDTH + ADDR_WIDTH + 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INST_WIDTH-1:0]    in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [UNIT_ID_WIDTH-1:0] out_unit_id,
    output logic [UNIT_ID_WIDTH-1:0] out_src_unit_id,
    output logic [2:0]               out_op,
    output logic [1:0]               out_comp,
    output logic [ADDR_WIDTH-1:0]    out_addr,
    output logic                     out_last,
    output logic                     err_illegal,
    input  logic                     err_clr,
    output logic [CNT_WIDTH-1:0]     illegal_cnt
);

    localparam int c_ptr_width  = $clog2(OUT_DEPTH);
    localparam int c_beat_width = 2*UNIT_ID_WIDTH + ADDR_WIDTH + 6;
    localparam logic [c_ptr_width:0] c_full_count = (c_ptr_width+1)'(OUT_DEPTH);

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_burst = 1'b1;

    logic [0:0]               r_state;
    logic [c_beat_width-1:0]  r_mem [OUT_DEPTH];
    logic [c_ptr_width-1:0]   r_wr_ptr;
    logic [c_ptr_width-1:0]   r_rd_ptr;
    logic [c_ptr_width:0]     r_count;
    logic [UNIT_ID_WIDTH-1:0] r_unit;
    logic [UNIT_ID_WIDTH-1:0] r_src;
    logic [2:0]               r_op;
    logic [1:0]               r_comp;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [2:0]               r_remaining;
    logic                     r_err;
    logic [CNT_WIDTH-1:0]     r_cnt;

    logic [2:0]               w_in_size;
    logic [ADDR_WIDTH-1:0]    w_in_addr;
    logic [1:0]               w_in_comp;
    logic [2:0]               w_in_op;
    logic [UNIT_ID_WIDTH-1:0] w_in_src;
    logic [UNIT_ID_WIDTH-1:0] w_in_unit;
    logic                     w_full;
    logic                     w_accept;
    logic                     w_illegal;
    logic                     w_pop;
    logic                     w_push;
    logic [c_beat_width-1:0]  w_push_beat;

    assign {w_in_unit, w_in_src, w_in_op, w_in_comp, w_in_addr, w_in_size} = in_inst;

    assign w_full    = (r_count == c_full_count);
    assign in_ready  = rst_n && (r_state == c_idle) && !w_full;
    assign w_accept  = in_valid && in_ready;
    assign w_illegal = (w_in_op[2:1] == 2'b11);
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;

    // Head is masked while empty so stale entries never reach the outputs.
    assign {out_unit_id, out_src_unit_id, out_op, out_comp, out_addr, out_last} =
        out_valid ? r_mem[r_rd_ptr] : '0;

    assign err_illegal = r_err;
    assign illegal_cnt = r_cnt;

    always_comb begin
        w_push      = 1'b0;
        w_push_beat = '0;
        if (r_state == c_idle) begin
            w_push      = w_accept && !w_illegal && (w_in_op != 3'b000);
            w_push_beat = {w_in_unit, w_in_src, w_in_op, w_in_comp, w_in_addr,
                           (w_in_size == 3'd0)};
        end else begin
            w_push      = !w_full;
            w_push_beat = {r_unit, r_src, r_op, r_comp, r_addr, (r_remaining == 3'd1)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_unit      <= '0;
            r_src       <= '0;
            r_op        <= '0;
            r_comp      <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_beat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (r_state == c_idle) begin
                if (w_push && (w_in_size != 3'd0)) begin
                    r_unit      <= w_in_unit;
                    r_src       <= w_in_src;
                    r_op        <= w_in_op;
                    r_comp      <= w_in_comp;
                    r_addr      <= w_in_addr + 1'b1;
                    r_remaining <= w_in_size;
                    r_state     <= c_burst;
                end
            end else if (w_push) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
                if (r_remaining == 3'd1) begin
                    r_state <= c_idle;
                end
            end

            // A new illegal word outranks a same-cycle clear.
            if (w_accept && w_illegal) begin
                r_err <= 1'b1;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accel_inst_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_inst_decoder
// Description : Directed, table-driven bench for accel_inst_decoder.
// Revision    : 1.0
// ============================================================================
module tb_accel_inst_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_unit_id;
    logic [7:0]  out_src_unit_id;
    logic [2:0]  out_op;
    logic [1:0]  out_comp;
    logic [3:0]  out_addr;
    logic        out_last;
    logic        err_illegal;
    logic        err_clr;
    logic [7:0]  illegal_cnt;

    logic        c2_in_ready;
    logic        c2_out_valid;
    logic [7:0]  c2_unit;
    logic [7:0]  c2_src;
    logic [2:0]  c2_op;
    logic [1:0]  c2_comp;
    logic [3:0]  c2_addr;
    logic        c2_last;
    logic        c2_err;
    logic [1:0]  c2_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    accel_inst_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_unit_id(out_unit_id), .out_src_unit_id(out_src_unit_id),
        .out_op(out_op), .out_comp(out_comp), .out_addr(out_addr),
        .out_last(out_last), .err_illegal(err_illegal), .err_clr(err_clr),
        .illegal_cnt(illegal_cnt)
    );

    accel_inst_decoder #(.CNT_WIDTH(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c2_in_ready),
        .in_inst(in_inst), .out_valid(c2_out_valid), .out_ready(out_ready),
        .out_unit_id(c2_unit), .out_src_unit_id(c2_src),
        .out_op(c2_op), .out_comp(c2_comp), .out_addr(c2_addr),
        .out_last(c2_last), .err_illegal(c2_err), .err_clr(err_clr),
        .illegal_cnt(c2_cnt)
    );

    typedef struct {
        logic [7:0] unit;
        logic [7:0] src;
        logic [2:0] op;
        logic [1:0] comp;
        logic [3:0] addr;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0] unit;
        logic [7:0] src;
        logic [2:0] op;
        logic [1:0] comp;
        logic [3:0] addr;
        logic [2:0] size;
        int         exp_beats;
        logic [3:0] exp_last_addr;
        logic       exp_err;
    } vec_t;

    beat_t got[$];
    vec_t  vecs[6];

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got.push_back('{out_unit_id, out_src_unit_id, out_op, out_comp, out_addr, out_last});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] mk(input logic [7:0] u, input logic [7:0] s,
                                       input logic [2:0] op, input logic [1:0] c,
                                       input logic [3:0] a, input logic [2:0] sz);
        return {u, s, op, c, a, sz};
    endfunction

    // Caller is aligned just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [27:0] inst);
        int n = 0;
        in_inst  = inst;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_fields"}, {out_unit_id, out_src_unit_id, out_op, out_comp, out_addr, out_last}, 0);
        check({tag, "_err"}, err_illegal, 0);
        check({tag, "_cnt"}, illegal_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        #1;
        check({tag, "_in_ready_rel"}, in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_inst   = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;

        vecs[0] = '{8'h03, 8'h00, 3'b001, 2'b00, 4'd5,  3'd0, 1, 4'd5,  1'b0};
        vecs[1] = '{8'hA5, 8'h5A, 3'b010, 2'b01, 4'd0,  3'd1, 2, 4'd1,  1'b0};
        vecs[2] = '{8'h11, 8'h22, 3'b100, 2'b10, 4'd15, 3'd2, 3, 4'd1,  1'b0};
        vecs[3] = '{8'hFF, 8'h01, 3'b101, 2'b11, 4'd9,  3'd7, 8, 4'd0,  1'b0};
        vecs[4] = '{8'h44, 8'h33, 3'b000, 2'b01, 4'd3,  3'd3, 0, 4'd0,  1'b0};
        vecs[5] = '{8'h55, 8'h66, 3'b111, 2'b00, 4'd7,  3'd2, 0, 4'd0,  1'b1};

        #2;
        apply_reset("por");

        // Single LOAD: beat visible in the cycle after the accept edge.
        out_ready = 1'b1;
        send(mk(8'd3, 8'd0, 3'b001, 2'b00, 4'd5, 3'd0));
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("lat_op", out_op, 3'b001);
        check("lat_addr", out_addr, 4'd5);
        check("lat_last", out_last, 1);
        check("lat_unit", out_unit_id, 8'd3);
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            got.delete();
            send(mk(vecs[v].unit, vecs[v].src, vecs[v].op, vecs[v].comp, vecs[v].addr, vecs[v].size));
            repeat (14) @(posedge clk);
            #1;
            check($sformatf("v%0d_beats", v), got.size(), vecs[v].exp_beats);
            for (int k = 0; k < got.size() && k < vecs[v].exp_beats; k++) begin
                logic [3:0] ea;
                ea = vecs[v].addr + 4'(k);
                check($sformatf("v%0d_b%0d_addr", v, k), got[k].addr, ea);
                check($sformatf("v%0d_b%0d_last", v, k), got[k].last, (k == vecs[v].exp_beats - 1));
                check($sformatf("v%0d_b%0d_fields", v, k),
                      {got[k].unit, got[k].src, got[k].op, got[k].comp},
                      {vecs[v].unit, vecs[v].src, vecs[v].op, vecs[v].comp});
            end
            if (vecs[v].exp_beats > 0 && got.size() >= vecs[v].exp_beats) begin
                check($sformatf("v%0d_last_addr", v), got[vecs[v].exp_beats-1].addr, vecs[v].exp_last_addr);
            end
            check($sformatf("v%0d_err", v), err_illegal, vecs[v].exp_err);
        end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;

        // Burst with address wrap: cycle-exact beats and in_ready held low.
        send(mk(8'd2, 8'd1, 3'b011, 2'b01, 4'd14, 3'd3));
        for (int k = 0; k < 4; k++) begin
            logic [3:0] ea;
            ea = 4'd14 + 4'(k);
            @(negedge clk);
            check($sformatf("wrap_valid%0d", k), out_valid, 1);
            check($sformatf("wrap_addr%0d", k), out_addr, ea);
            check($sformatf("wrap_last%0d", k), out_last, (k == 3));
            check($sformatf("wrap_in_ready%0d", k), in_ready, (k == 3));
        end
        @(negedge clk);
        check("wrap_drained", out_valid, 0);
        @(posedge clk);
        #1;

        // Backpressure: FIFO fills, then drains in order without loss.
        out_ready = 1'b0;
        got.delete();
        send(mk(8'd7, 8'd8, 3'b001, 2'b00, 4'd0, 3'd7));
        repeat (6) @(negedge clk);
        check("bp_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        check("bp_head_addr", out_addr, 4'd0);
        check("bp_head_last", out_last, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("bp_beats", got.size(), 8);
        for (int k = 0; k < got.size() && k < 8; k++) begin
            check($sformatf("bp_addr%0d", k), got[k].addr, 4'(k));
            check($sformatf("bp_last%0d", k), got[k].last, (k == 7));
        end

        // Illegal-opcode accounting and error clear.
        apply_reset("rst2");
        out_ready = 1'b1;
        repeat (3) send(mk(8'd1, 8'd1, 3'b110, 2'b00, 4'd0, 3'd0));
        send(mk(8'd1, 8'd1, 3'b000, 2'b00, 4'd0, 3'd0));
        repeat (3) @(posedge clk);
        #1;
        check("ill_no_beats", got.size(), 0);
        check("ill_err", err_illegal, 1);
        check("ill_cnt3", illegal_cnt, 3);
        check("ill_c2_cnt3", c2_cnt, 3);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("clr_err", err_illegal, 0);
        check("clr_cnt_kept", illegal_cnt, 3);
        send(mk(8'd1, 8'd1, 3'b111, 2'b00, 4'd0, 3'd0));
        send(mk(8'd1, 8'd1, 3'b110, 2'b00, 4'd0, 3'd0));
        check("sat_c2_cnt", c2_cnt, 3);
        check("cnt5", illegal_cnt, 5);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr2_err", err_illegal, 0);
        send(mk(8'd1, 8'd1, 3'b111, 2'b00, 4'd0, 3'd0));
        err_clr = 1'b0;
        check("set_wins_err", err_illegal, 1);
        check("cnt6", illegal_cnt, 6);

        // Reset during the second beat of a burst.
        send(mk(8'd9, 8'd4, 3'b001, 2'b00, 4'd2, 3'd5));
        @(posedge clk);
        #1;
        check("mid_beat1_addr", out_addr, 4'd3);
        apply_reset("mid");
        repeat (8) @(posedge clk);
        #1;
        check("mid_no_beats", got.size(), 0);
        check("mid_valid", out_valid, 0);
        send(mk(8'd3, 8'd0, 3'b001, 2'b00, 4'd5, 3'd0));
        repeat (4) @(posedge clk);
        #1;
        check("post_beats", got.size(), 1);
        if (got.size() >= 1) begin
            check("post_fields", {got[0].unit, got[0].op, got[0].addr, got[0].last},
                  {8'd3, 3'b001, 4'd5, 1'b1});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
